// File: rtl/sbox_iter_engine_pkg.sv
// Shared definitions for the iterated S-box engine.
//   - state_t : engine state encoding (ST_IDLE / ST_RUN / ST_DONE)
//   - SBOX_W  : width of one S-box lane
//   - sbox_fwd / sbox_inv : AES S-box and its inverse, computed as the
//     GF(2^8) multiplicative inverse combined with the AES affine map.
package sbox_iter_engine_pkg;

    localparam int SBOX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse for a != 0 and maps 0 to 0,
    // which is exactly the convention the AES S-box uses.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0] y;
        y = gf_inv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/sbox_iter_engine_if.sv
// Command/status bundle of the iterated S-box engine.
//   start, inv, rounds, value_in : driven by the master (requester)
//   busy, done, value_out        : driven by the slave (engine)
interface sbox_iter_engine_if #(
    parameter int LANES = 4,
    parameter int CNT_W = 4
);
    logic               start;
    logic               inv;
    logic [CNT_W-1:0]   rounds;
    logic [8*LANES-1:0] value_in;
    logic               busy;
    logic               done;
    logic [8*LANES-1:0] value_out;

    modport master (
        output start, inv, rounds, value_in,
        input  busy, done, value_out
    );

    modport slave (
        input  start, inv, rounds, value_in,
        output busy, done, value_out
    );
endinterface

// File: rtl/sbox_lane.sv
// One byte lane: forward and inverse AES S-box with a 2:1 output select.
//   din  : input byte
//   inv  : 0 = forward S-box, 1 = inverse S-box
//   dout : substituted byte (purely combinational)
module sbox_lane
    import sbox_iter_engine_pkg::*;
(
    input  logic [SBOX_W-1:0] din,
    input  logic              inv,
    output logic [SBOX_W-1:0] dout
);
    logic [SBOX_W-1:0] fwd_byte;
    logic [SBOX_W-1:0] inv_byte;

    assign fwd_byte = sbox_fwd(din);
    assign inv_byte = sbox_inv(din);
    assign dout     = inv ? inv_byte : fwd_byte;
endmodule

// File: rtl/sbox_iter_engine.sv
// Iterated S-box engine: on an accepted start it applies the forward or
// inverse S-box to every byte of a word for a programmable number of rounds,
// then holds the result with done until the next accepted start.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : slave side of sbox_iter_engine_if
//          (start/inv/rounds/value_in in, busy/done/value_out out)
module sbox_iter_engine
    import sbox_iter_engine_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    sbox_iter_engine_if.slave bus
);
    state_t             state_q, state_d;
    logic [8*LANES-1:0] data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;

    logic               accept;
    logic               lane_inv;
    logic [8*LANES-1:0] operand;
    logic [8*LANES-1:0] sbox_out;

    // A new operation can only be taken when no iteration is in flight.
    assign accept = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    // The accepting edge substitutes the incoming word with the incoming
    // mode; every later edge iterates on the register with the latched mode.
    assign operand  = accept ? bus.value_in : data_q;
    assign lane_inv = accept ? bus.inv      : mode_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane u_lane (
            .din  (operand[8*i +: 8]),
            .inv  (lane_inv),
            .dout (sbox_out[8*i +: 8])
        );
    end

    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (bus.rounds == '0) begin
                        data_d  = bus.value_in;
                        state_d = ST_DONE;
                    end else if (bus.rounds == CNT_W'(1)) begin
                        data_d  = sbox_out;
                        state_d = ST_DONE;
                    end else begin
                        data_d  = sbox_out;
                        cnt_d   = bus.rounds - CNT_W'(1);
                        mode_d  = bus.inv;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                data_d = sbox_out;
                cnt_d  = cnt_q - CNT_W'(1);
                // cnt counts remaining rounds; leaving at 1 means it never wraps.
                if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.value_out = data_q;
endmodule
